// File: rtl/mux_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux_arb_pkg
//   Shared types and helpers for the two-requester round-robin mux arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, OWN0, OWN1)
//   - cnt_width() : width of the burst counter, max(1, $clog2(max_burst))
// ----------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // The counter only has to reach max_burst-1, so $clog2(max_burst) bits
  // suffice; a single-transfer burst still needs one bit to exist at all.
  function automatic int cnt_width(input int max_burst);
    int w;
    w = $clog2(max_burst);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : mux_arb_pkg

// File: rtl/mux_w.sv
// ----------------------------------------------------------------------------
// mux_w
//   WIDTH-bit combinational 2:1 multiplexer.
//   Ports:
//     D0 : input  [WIDTH-1:0]  selected when S = 0
//     D1 : input  [WIDTH-1:0]  selected when S = 1
//     S  : input               select
//     Q  : output [WIDTH-1:0]  selected data
// ----------------------------------------------------------------------------
module mux_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             S,
  output logic [WIDTH-1:0] Q
);

  assign Q = S ? D1 : D0;

endmodule : mux_w

// File: rtl/mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter
//   Two-requester round-robin arbiter owning the select of a shared 2:1 mux.
//   A requester keeps the resource for up to MAX_BURST transfers while the
//   other side waits; with no competition the burst window simply restarts.
//   The selected data is registered onto q with a one-cycle valid strobe.
//   Ports:
//     clk     : input               rising-edge clock
//     rst     : input               asynchronous reset, active-high
//     req0/1  : input               requester wants the resource
//     d0/d1   : input  [WIDTH-1:0]  requester data
//     gnt0/1  : output              requester owns the resource
//     sel     : output              mux select (0 = d0, 1 = d1), holds in IDLE
//     q       : output [WIDTH-1:0]  registered shared data
//     q_valid : output              q holds a transfer from the previous cycle
// ----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_e       r_state, w_state_nxt;
  logic             r_last,  w_last_nxt;   // last owner, loser of the next tie
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;    // transfers done in this tenure
  logic             r_sel,   w_sel_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic [WIDTH-1:0] w_mux;
  logic             w_xfer;

  // --------------------------------------------------------------------------
  // Shared data mux, steered by the registered select
  // --------------------------------------------------------------------------
  mux_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .D0 (d0),
    .D1 (d1),
    .S  (r_sel),
    .Q  (w_mux)
  );

  // A transfer needs the owner to still be requesting in this cycle.
  assign w_xfer = ((r_state == OWN0) && req0) ||
                  ((r_state == OWN1) && req1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / bookkeeping logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (req0 && req1)
          w_state_nxt = r_last ? OWN0 : OWN1;
        else if (req0)
          w_state_nxt = OWN0;
        else if (req1)
          w_state_nxt = OWN1;
      end

      OWN0: begin
        if (!req0) begin
          // Release: no transfer this cycle, costs one dead cycle.
          w_last_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = req1 ? OWN1 : IDLE;
        end else if (r_cnt == CNT_LAST) begin
          // Burst limit: hand over with no dead cycle only if someone waits.
          w_cnt_nxt = '0;
          if (req1) begin
            w_state_nxt = OWN1;
            w_last_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      OWN1: begin
        if (!req1) begin
          w_last_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = req0 ? OWN0 : IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (req0) begin
            w_state_nxt = OWN0;
            w_last_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Select follows ownership and keeps its last value while idle.
  always_comb begin
    w_sel_nxt = r_sel;
    case (w_state_nxt)
      OWN0:    w_sel_nxt = 1'b0;
      OWN1:    w_sel_nxt = 1'b1;
      default: w_sel_nxt = r_sel;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered output stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_xfer;
      if (w_xfer)
        r_q <= w_mux;
    end
  end

  assign gnt0    = (r_state == OWN0);
  assign gnt1    = (r_state == OWN1);
  assign sel     = r_sel;
  assign q       = r_q;
  assign q_valid = r_q_valid;

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter: a MAX_BURST = 4 instance (dut) and a
//   MAX_BURST = 1 instance (dut1) sharing clock and reset.
// ----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       gnt0, gnt1, sel, q_valid;
  logic [7:0] q;

  logic       b_req0, b_req1;
  logic [7:0] b_d0, b_d1;
  logic       b_gnt0, b_gnt1, b_sel, b_q_valid;
  logic [7:0] b_q;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .q(q), .q_valid(q_valid)
  );

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .d0(b_d0), .d1(b_d1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel), .q(b_q), .q_valid(b_q_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and check grant exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl_gnt",  32'(gnt0 & gnt1), 32'd0);
    chk("excl_gnt1", 32'(b_gnt0 & b_gnt1), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; d0 = 0; d1 = 0;
    b_req0 = 0; b_req1 = 0; b_d0 = 0; b_d1 = 0;
    #12;
    // Reset state
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_sel",  32'(sel), 0);
    chk("rst_q",    32'(q), 0);
    chk("rst_qv",   32'(q_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- Single requester, 10 transfers, counter wraps silently ----------
    req0 = 1; d0 = 8'h10;
    tick();
    chk("single_grant_gnt0", 32'(gnt0), 1);
    chk("single_grant_qv",   32'(q_valid), 0);
    for (int i = 0; i < 10; i++) begin
      d0 = 8'(8'h10 + i);
      tick();
      chk("single_q",    32'(q), 32'(8'h10 + i));
      chk("single_qv",   32'(q_valid), 1);
      chk("single_gnt0", 32'(gnt0), 1);
      chk("single_sel",  32'(sel), 0);
    end
    req0 = 0;
    tick();  // release to IDLE, last = 0
    chk("rel_gnt0", 32'(gnt0), 0);
    chk("rel_qv",   32'(q_valid), 0);
    chk("rel_qhold", 32'(q), 32'h19);

    // ---- Contention, MAX_BURST = 4; last = 0 so requester 1 goes first ----
    req0 = 1; req1 = 1; d0 = 8'hA0; d1 = 8'hB1;
    tick();
    chk("cont_first_gnt1", 32'(gnt1), 1);
    chk("cont_first_sel",  32'(sel), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("cont_q",  32'(q), ((i / 4) % 2 == 0) ? 32'hB1 : 32'hA0);
      chk("cont_qv", 32'(q_valid), 1);
      chk("cont_sel", 32'(sel), (((i + 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
    end
    // Now OWN0 with a fresh window.

    // ---- Early release after 2 transfers ---------------------------------
    tick(); chk("early_q0", 32'(q), 32'hA0);
    tick(); chk("early_q1", 32'(q), 32'hA0);
    req0 = 0;
    tick();
    chk("early_dead_qv", 32'(q_valid), 0);
    chk("early_gnt1",    32'(gnt1), 1);
    chk("early_qhold",   32'(q), 32'hA0);
    tick();
    chk("early_q_d1", 32'(q), 32'hB1);
    chk("early_qv",   32'(q_valid), 1);
    req1 = 0;
    tick();  // release by requester 1, last = 1
    chk("idle_gnt1",    32'(gnt1), 0);
    chk("idle_selhold", 32'(sel), 1);

    // ---- Tie after idle: last was requester 1 -> requester 0 wins --------
    tick();
    req0 = 1; req1 = 1;
    tick();
    chk("tie_gnt0", 32'(gnt0), 1);
    chk("tie_sel",  32'(sel), 0);
    d0 = 8'h55;
    tick();
    chk("tie_q", 32'(q), 32'h55);
    req1 = 0;

    // ---- Asynchronous reset mid-tenure -----------------------------------
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt0", 32'(gnt0), 0);
    chk("arst_qv",   32'(q_valid), 0);
    chk("arst_q",    32'(q), 0);
    chk("arst_sel",  32'(sel), 0);
    tick();
    rst = 1'b0;
    req1 = 1;
    tick();
    chk("arst_tie_gnt0", 32'(gnt0), 1);
    req0 = 0; req1 = 0;

    // ---- MAX_BURST = 1: strict alternation -------------------------------
    b_req0 = 1; b_req1 = 1; b_d0 = 8'hA0; b_d1 = 8'hB1;
    tick();
    chk("mb1_first_gnt0", 32'(b_gnt0), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mb1_q",    32'(b_q), (i % 2 == 0) ? 32'hA0 : 32'hB1);
      chk("mb1_qv",   32'(b_q_valid), 1);
      chk("mb1_gnt1", 32'(b_gnt1), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    b_req0 = 0; b_req1 = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux_rr_arbiter
